// File: rtl/gate_sweep_controller.sv
// Sweeps a stimulus vector through the combinational gate datapath, waits a settle
// time for each vector, and folds the 9-bit result into a rotate-xor signature.
module gate_sweep_controller #(
  parameter int DWELL_CYCLES = 4,
  parameter int SWEEP_BITS   = 18
) (
  input  logic        CLOCK_50_I,
  input  logic        RESET_I,
  input  logic        START_I,
  input  logic        PAUSE_I,
  input  logic        MODE_I,
  input  logic [8:0]  RESULT_I,
  output logic [17:0] STIM_O,
  output logic [8:0]  SIGNATURE_O,
  output logic [18:0] STEP_COUNT_O,
  output logic        BUSY_O,
  output logic        DONE_O
);

  localparam int              DW         = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [18:0]     SWEEP_SPAN = 19'(1) << SWEEP_BITS;
  localparam logic [17:0]     SWEEP_MASK = 18'(SWEEP_SPAN - 19'd1);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    CAPTURE,
    HOLD,
    DONE
  } state_t;

  state_t        state;
  logic          start_q;
  logic          start_edge;
  logic          sweep_last;
  logic [DW-1:0] dwell;

  assign start_edge = START_I & ~start_q;
  assign sweep_last = (STIM_O & SWEEP_MASK) == SWEEP_MASK;

  assign BUSY_O = (state == APPLY) || (state == CAPTURE) || (state == HOLD);
  assign DONE_O = (state == DONE);

  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking = would let later lines see half-updated state.
  always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
    if (RESET_I) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      dwell        <= '0;
      STIM_O       <= '0;
      SIGNATURE_O  <= '0;
      STEP_COUNT_O <= '0;
    end else begin
      start_q <= START_I;
      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            state        <= APPLY;
            dwell        <= '0;
            STIM_O       <= '0;
            SIGNATURE_O  <= '0;
            STEP_COUNT_O <= '0;
          end
        end

        APPLY: begin
          if (!PAUSE_I) begin
            if (dwell == DWELL_LAST) state <= CAPTURE;
            else                     dwell <= dwell + 1'b1;
          end
        end

        CAPTURE: begin
          SIGNATURE_O  <= {SIGNATURE_O[7:0], SIGNATURE_O[8]} ^ RESULT_I;
          STEP_COUNT_O <= STEP_COUNT_O + 19'd1;
          // The last pattern leaves STIM_O in place, so the increment never wraps.
          if (sweep_last) begin
            state <= DONE;
          end else begin
            STIM_O <= (STIM_O + 18'd1) & SWEEP_MASK;
            dwell  <= '0;
            state  <= MODE_I ? HOLD : APPLY;
          end
        end

        HOLD: begin
          if (start_edge) begin
            state <= APPLY;
            dwell <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Bench for gate_sweep_controller: a free-running instance (3 bits, dwell 2) and a
// single-step instance (2 bits, dwell 2), checked against a per-cycle trace model.
module tb_gate_sweep_controller;

  localparam int D    = 2;
  localparam int SB   = 3;
  localparam int SB_S = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, pause, mode;
  logic [8:0]  result;
  logic [17:0] stim;
  logic [8:0]  sig;
  logic [18:0] count;
  logic        busy, done;
  logic [8:0]  res_tab [8];
  logic        use_tab;

  assign result = use_tab ? res_tab[stim[2:0]] : stim[8:0];

  logic        start_s, pause_s, mode_s;
  logic [8:0]  result_s;
  logic [17:0] stim_s;
  logic [8:0]  sig_s;
  logic [18:0] count_s;
  logic        busy_s, done_s;
  logic [8:0]  res_tab_s [4];

  assign result_s = res_tab_s[stim_s[1:0]];

  gate_sweep_controller #(.DWELL_CYCLES(D), .SWEEP_BITS(SB)) dut (
    .CLOCK_50_I  (clk),
    .RESET_I     (rst),
    .START_I     (start),
    .PAUSE_I     (pause),
    .MODE_I      (mode),
    .RESULT_I    (result),
    .STIM_O      (stim),
    .SIGNATURE_O (sig),
    .STEP_COUNT_O(count),
    .BUSY_O      (busy),
    .DONE_O      (done)
  );

  gate_sweep_controller #(.DWELL_CYCLES(D), .SWEEP_BITS(SB_S)) dut_step (
    .CLOCK_50_I  (clk),
    .RESET_I     (rst),
    .START_I     (start_s),
    .PAUSE_I     (pause_s),
    .MODE_I      (mode_s),
    .RESULT_I    (result_s),
    .STIM_O      (stim_s),
    .SIGNATURE_O (sig_s),
    .STEP_COUNT_O(count_s),
    .BUSY_O      (busy_s),
    .DONE_O      (done_s)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Signature over the whole sweep of the free-running instance.
  function automatic logic [8:0] model_sig_main();
    logic [8:0] s = '0;
    for (int v = 0; v < (1 << SB); v++)
      s = {s[7:0], s[8]} ^ (use_tab ? res_tab[v] : 9'(v));
    return s;
  endfunction

  function automatic logic [8:0] model_sig_step();
    logic [8:0] s = '0;
    for (int v = 0; v < (1 << SB_S); v++)
      s = {s[7:0], s[8]} ^ res_tab_s[v];
    return s;
  endfunction

  // One complete sweep from IDLE or DONE. Vector pv is paused for plen cycles at its
  // first APPLY cycle; START is held for hold_len cycles and re-pulsed at repulse_at.
  task automatic run_sweep(input string name, input int pv, input int plen,
                           input int hold_len, input int repulse_at,
                           input logic [8:0] exp_sig);
    int   q[$];
    int   len, errs, upper_errs, done_at, pause_left;
    bit   paused;
    for (int v = 0; v < (1 << SB); v++)
      repeat (D + 1 + ((v == pv) ? plen : 0)) q.push_back(v);
    len = q.size();
    errs = 0; upper_errs = 0; done_at = -1; pause_left = 0; paused = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total_cnt++;
        if ({sig, count, done, busy} !== {9'd0, 19'd0, 1'b0, 1'b1})
          $display("FAIL %s apply_entry: sig=%h count=%0d done=%b busy=%b, required 000/0/0/1",
                   name, sig, count, done, busy);
        else pass_cnt++;
      end
      if (k <= len && (stim !== 18'(q[k-1]) || busy !== 1'b1 || done !== 1'b0)) errs++;
      if (stim[17:SB] !== '0) upper_errs++;
      if (done === 1'b1 && done_at < 0) done_at = k;
      if (k == hold_len) start = 1'b0;
      if (repulse_at > 0 && k == repulse_at) start = 1'b1;
      if (repulse_at > 0 && k == repulse_at + 1) start = 1'b0;
      if (pause_left > 0) begin
        pause_left--;
        if (pause_left == 0) pause = 1'b0;
      end else if (!paused && plen > 0 && stim == 18'(pv)) begin
        pause = 1'b1; pause_left = plen; paused = 1;
      end
    end
    start = 1'b0;
    pause = 1'b0;
    total_cnt++;
    if (errs != 0) $display("FAIL %s trace: %0d mismatching cycles, required 0", name, errs);
    else pass_cnt++;
    total_cnt++;
    if (upper_errs != 0) $display("FAIL %s upper_bits: %0d nonzero cycles, required 0", name, upper_errs);
    else pass_cnt++;
    total_cnt++;
    if (done_at != len + 1) $display("FAIL %s done_time: cycle %0d, required %0d", name, done_at, len + 1);
    else pass_cnt++;
    total_cnt++;
    if (sig !== exp_sig) $display("FAIL %s signature: got %h, required %h", name, sig, exp_sig);
    else pass_cnt++;
    total_cnt++;
    if ({count, stim, done, busy} !== {19'(1 << SB), 18'((1 << SB) - 1), 1'b1, 1'b0})
      $display("FAIL %s final: count=%0d stim=%0d done=%b busy=%b, required %0d/%0d/1/0",
               name, count, stim, done, busy, 1 << SB, (1 << SB) - 1);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({stim, sig, count, busy, done} !== '0)
      $display("FAIL reset_main: stim=%h sig=%h count=%0d busy=%b done=%b, required all 0",
               stim, sig, count, busy, done);
    else pass_cnt++;
    total_cnt++;
    if ({stim_s, sig_s, count_s, busy_s, done_s} !== '0)
      $display("FAIL reset_step: stim=%h sig=%h count=%0d busy=%b done=%b, required all 0",
               stim_s, sig_s, count_s, busy_s, done_s);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_free_sweep();
    use_tab = 1'b0;
    run_sweep("free", -1, 0, 1, 0, 9'h00F);
  endtask

  task automatic test_pause();
    run_sweep("pause", 3, 5, 1, 0, 9'h00F);
  endtask

  task automatic test_restart();
    run_sweep("restart", -1, 0, 1, 0, 9'h00F);
  endtask

  task automatic test_start_held();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_sweep("start_held", -1, 0, 10, 13, 9'h00F);
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (stim == 18'd5) seen = 1;
    end
    total_cnt++;
    if (!seen) $display("FAIL async_reach: vector 5 not seen within 40 cycles, required seen");
    else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    total_cnt++;
    if ({stim, sig, count, busy, done} !== '0)
      $display("FAIL async_reset: stim=%h sig=%h count=%0d busy=%b done=%b, required all 0 before edge",
               stim, sig, count, busy, done);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({stim, busy, done} !== '0)
      $display("FAIL async_idle: stim=%h busy=%b done=%b, required idle with all 0", stim, busy, done);
    else pass_cnt++;
    run_sweep("after_reset", -1, 0, 1, 0, 9'h00F);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      use_tab = 1'b1;
      for (int v = 0; v < 8; v++) res_tab[v] = 9'($urandom);
      run_sweep($sformatf("random%0d", it), $urandom_range(0, 7), $urandom_range(0, 6),
                $urandom_range(1, 4), 0, model_sig_main());
    end
    use_tab = 1'b0;
  endtask

  task automatic test_single_step();
    mode_s = 1'b1;
    for (int v = 0; v < 4; v++) res_tab_s[v] = 9'($urandom);
    for (int v = 0; v < (1 << SB_S); v++) begin
      @(negedge clk);
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      repeat (D + 1) @(negedge clk);
      if (v < (1 << SB_S) - 1) begin
        total_cnt++;
        if ({busy_s, done_s, stim_s, count_s} !== {1'b1, 1'b0, 18'(v + 1), 19'(v + 1)})
          $display("FAIL step%0d_hold: busy=%b done=%b stim=%0d count=%0d, required 1/0/%0d/%0d",
                   v, busy_s, done_s, stim_s, count_s, v + 1, v + 1);
        else pass_cnt++;
        pause_s = 1'($urandom);
        repeat ($urandom_range(2, 5)) @(negedge clk);
        total_cnt++;
        if ({busy_s, stim_s, count_s} !== {1'b1, 18'(v + 1), 19'(v + 1)})
          $display("FAIL step%0d_wait: busy=%b stim=%0d count=%0d, required 1/%0d/%0d",
                   v, busy_s, stim_s, count_s, v + 1, v + 1);
        else pass_cnt++;
        pause_s = 1'b0;
      end else begin
        total_cnt++;
        if ({done_s, busy_s, stim_s, count_s} !== {1'b1, 1'b0, 18'd3, 19'd4})
          $display("FAIL step_done: done=%b busy=%b stim=%0d count=%0d, required 1/0/3/4",
                   done_s, busy_s, stim_s, count_s);
        else pass_cnt++;
        total_cnt++;
        if (sig_s !== model_sig_step())
          $display("FAIL step_signature: got %h, required %h", sig_s, model_sig_step());
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; mode = 1'b0; use_tab = 1'b0;
    start_s = 1'b0; pause_s = 1'b0; mode_s = 1'b0;
    for (int v = 0; v < 8; v++) res_tab[v] = '0;
    for (int v = 0; v < 4; v++) res_tab_s[v] = '0;
    test_reset();
    test_free_sweep();
    test_pause();
    test_restart();
    test_start_held();
    test_async_reset();
    test_random();
    test_single_step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
